// File: rtl/slr_pkg.sv
// rtl/slr_pkg.sv - shared SLR crossing helpers: round-trip sizing and parameter legality
package slr_pkg;

    // Beats that can still land after ready falls: forward + reverse crossing latency plus one.
    function automatic int slr_round_trip(input int regs_before, input int regs_after);
        return 2 * (regs_before + 2 + regs_after) + 1;
    endfunction

    function automatic bit slr_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit slr_params_legal(input int depth, input int round_trip);
        return (depth >= 4) && slr_is_pow2(depth) && (round_trip < depth) && (round_trip >= 0);
    endfunction

endpackage

// File: rtl/slr_rx_credit_fifo.sv
// rtl/slr_rx_credit_fifo.sv - receive skid FIFO absorbing in-flight beats behind a registered up_ready
module slr_rx_credit_fifo
    import slr_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ROUND_TRIP = 8
) (
    input  logic                       clk,
    input  logic                       sreset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       up_ready,
    output logic                       m_valid,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW-1:0] CREDIT_LIMIT = CW'(DEPTH - ROUND_TRIP);

    generate
        if (!slr_params_legal(DEPTH, ROUND_TRIP)) begin : g_bad_params
            $error("slr_rx_credit_fifo: DEPTH must be a power of two >= 4 and ROUND_TRIP < DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             pop;
    logic             accept;
    logic             drop;

    assign m_valid    = (count != '0);
    assign m_data     = mem[rd_ptr];
    assign fill_level = count;

    // A pop frees the slot in the same edge, so a full buffer still accepts when read.
    assign pop    = m_valid & m_ready;
    assign accept = in_valid & ((count < FULL_COUNT) | pop);
    assign drop   = in_valid & ~accept;

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            up_ready <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            // Free space strictly above ROUND_TRIP leaves room for everything still in flight.
            up_ready <= (count_next < CREDIT_LIMIT);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
